// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding and the
// default reset PC / instruction-memory depth used by fetch_ctrl and
// fetch_tgt_chk.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/fetch_tgt_chk.sv
// Combinational legality check of a redirect target: word aligned and inside
// the instruction memory window [RESET_PC, RESET_PC + 4*IM_WORDS).
// Ports: tgt (candidate address) -> legal (1 when the target may be fetched).
module fetch_tgt_chk
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic [31:0] tgt,
  output logic        legal
);

  // Bounds are widened to 34 bits so the upper limit cannot wrap when the
  // window ends at the top of the 32-bit address space.
  localparam logic [33:0] LO = {2'b00, RESET_PC};
  localparam logic [33:0] HI = LO + (34'(IM_WORDS) << 2);

  logic [33:0] tgt_x;

  assign tgt_x = {2'b00, tgt};
  assign legal = (tgt[1:0] == 2'b00) && (tgt_x >= LO) && (tgt_x < HI);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: selects the next fetch PC, freezes fetch on
// stall, buffers redirects that arrive while fetch is frozen, injects nops,
// and traps on illegal redirect targets.
// Ports: clk, reset (async active-low), stall, br_valid/br_target (D-stage
// redirect), F_PC (current fetch PC) -> NPC, F_en, clear, pc_err, redir_cnt.
// Build option: FETCH_CTRL_DELAY_SLOT_EN keeps the F-stage instruction on an
// applied redirect (delay slot); undefined, the wrong-path instruction is
// cleared.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic [31:0] F_PC,
  output logic [31:0] NPC,
  output logic        F_en,
  output logic        clear,
  output logic        pc_err,
  output logic [15:0] redir_cnt
);

  fetch_state_t state_q, state_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         pc_err_q;
  logic [15:0]  redir_cnt_q;
  logic         tgt_legal;
  logic         set_err;
  logic         redir;

  fetch_tgt_chk #(
    .RESET_PC (RESET_PC),
    .IM_WORDS (IM_WORDS)
  ) u_tgt_chk (
    .tgt   (br_target),
    .legal (tgt_legal)
  );

  always_comb begin
    state_d    = state_q;
    NPC        = F_PC;
    F_en       = 1'b0;
    clear      = 1'b0;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    set_err    = 1'b0;
    redir      = 1'b0;
    case (state_q)
      BOOT: begin
        NPC     = RESET_PC;
        clear   = 1'b1;
        state_d = RUN;
        // Fetch is frozen here, so a legal redirect is held for the first
        // RUN cycle rather than lost.
        if (br_valid && tgt_legal) begin
          pend_v_d   = 1'b1;
          pend_tgt_d = br_target;
        end
      end
      RUN, HOLD: begin
        if (br_valid && !tgt_legal) begin
          // Trap without applying or buffering the bad target; the F-stage
          // instruction is killed since fetch stops here.
          set_err = 1'b1;
          clear   = 1'b1;
          state_d = ERR;
        end else if (stall) begin
          state_d = HOLD;
          if (br_valid) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = br_target;
          end
        end else begin
          state_d = RUN;
          F_en    = 1'b1;
          if (br_valid) begin
            NPC   = br_target;
            redir = 1'b1;
          end else if (pend_v_q) begin
            NPC   = pend_tgt_q;
            redir = 1'b1;
          end else begin
            NPC = F_PC + 32'd4;
          end
          // A fresh redirect supersedes any buffered one, so the pending
          // entry is retired on every applied redirect.
          if (redir) begin
            pend_v_d = 1'b0;
          end
`ifdef FETCH_CTRL_DELAY_SLOT_EN
          clear = 1'b0;
`else
          clear = redir;
`endif
        end
      end
      ERR: begin
        clear = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= 32'd0;
      pc_err_q    <= 1'b0;
      redir_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      if (set_err) begin
        pc_err_q <= 1'b1;
      end
      if (redir && (redir_cnt_q != 16'hFFFF)) begin
        redir_cnt_q <= redir_cnt_q + 16'd1;
      end
    end
  end

  assign pc_err    = pc_err_q;
  assign redir_cnt = redir_cnt_q;

endmodule
